// File: rtl/peripheral_bus_bridge.sv
// Wishbone-to-peripheral-bus bridge: one outstanding single-beat transfer, with a
// busy-driven wait/timeout and a one-cycle ack or error response.
module peripheral_bus_bridge #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    output logic        wb_error_o,
    output logic        wb_stall_o,
    output logic [31:0] wb_data_o,
    output logic        peripheralEnable,
    output logic [15:0] peripheralBus_address,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    input  logic        peripheralBus_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] addr_r, addr_s;
    logic        we_r, we_s;
    logic [3:0]  sel_r, sel_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] rdata_r, rdata_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        ack_r, ack_s;
    logic        err_r, err_s;
    logic        stall_r, stall_s;
    logic        en_r, en_s;
    logic        pwe_r, pwe_s;
    logic        poe_r, poe_s;

    // Next-state and next-output logic; every output is derived from the next state so it can be registered.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        we_s    = we_r;
        sel_s   = sel_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        cnt_s   = cnt_r;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_s  = wb_adr_i;
                    we_s    = wb_we_i;
                    sel_s   = wb_sel_i;
                    wdata_s = wb_data_i;
                    cnt_s   = 8'd0;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Dropping cyc abandons the transfer silently, even if it would have completed.
                if (!wb_cyc_i) begin
                    state_s = IDLE;
                end else if (!peripheralBus_busy) begin
                    if (!we_r) begin
                        rdata_s = peripheralBus_dataRead;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    ack_s   = 1'b1;
                    state_s = RESPOND;
                end else if (cnt_r == (TIMEOUT_CYCLES - 8'd1)) begin
                    err_s   = 1'b1;
                    state_s = RESPOND;
                end else if (cnt_r != 8'hFF) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RESPOND: begin
                rdata_s = 32'd0;
                state_s = IDLE;
            end
            default: begin
                rdata_s = 32'd0;
                state_s = IDLE;
            end
        endcase
        en_s    = (state_s == ACCESS);
        stall_s = (state_s != IDLE);
        pwe_s   = en_s & we_s;
        poe_s   = en_s & ~we_s;
    end

    // State, latched transfer fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= 16'd0;
            we_r    <= 1'b0;
            sel_r   <= 4'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            cnt_r   <= 8'd0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            stall_r <= 1'b0;
            en_r    <= 1'b0;
            pwe_r   <= 1'b0;
            poe_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            we_r    <= we_s;
            sel_r   <= sel_s;
            wdata_r <= wdata_s;
            rdata_r <= rdata_s;
            cnt_r   <= cnt_s;
            ack_r   <= ack_s;
            err_r   <= err_s;
            stall_r <= stall_s;
            en_r    <= en_s;
            pwe_r   <= pwe_s;
            poe_r   <= poe_s;
        end
    end

    assign wb_ack_o                 = ack_r;
    assign wb_error_o               = err_r;
    assign wb_stall_o               = stall_r;
    assign wb_data_o                = rdata_r;
    assign peripheralEnable         = en_r;
    assign peripheralBus_address    = addr_r;
    assign peripheralBus_we         = pwe_r;
    assign peripheralBus_oe         = poe_r;
    assign peripheralBus_byteSelect = sel_r;
    assign peripheralBus_dataWrite  = wdata_r;

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// Scoreboard bench for peripheral_bus_bridge: stimulus queues expected responses,
// a negedge monitor pops and compares whenever ack or error appears.
module tb_peripheral_bus_bridge;

    logic        clk;
    logic        rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [15:0] wb_adr_i;
    logic [31:0] wb_data_i;
    logic        wb_ack_o;
    logic        wb_error_o;
    logic        wb_stall_o;
    logic [31:0] wb_data_o;
    logic        peripheralEnable;
    logic [15:0] peripheralBus_address;
    logic        peripheralBus_we;
    logic        peripheralBus_oe;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead;
    logic        peripheralBus_busy;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    peripheral_bus_bridge #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .wb_cyc_i                 (wb_cyc_i),
        .wb_stb_i                 (wb_stb_i),
        .wb_we_i                  (wb_we_i),
        .wb_sel_i                 (wb_sel_i),
        .wb_adr_i                 (wb_adr_i),
        .wb_data_i                (wb_data_i),
        .wb_ack_o                 (wb_ack_o),
        .wb_error_o               (wb_error_o),
        .wb_stall_o               (wb_stall_o),
        .wb_data_o                (wb_data_o),
        .peripheralEnable         (peripheralEnable),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .peripheralBus_busy       (peripheralBus_busy)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic [31:0] data);
        resp_t r;
        r.err  = err;
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Zero-wait read: enable one cycle, ack two cycles after acceptance, data then clears.
    task automatic read0(input logic [15:0] adr, input logic [31:0] data);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_adr_i = adr; peripheralBus_busy = 1'b0; peripheralBus_dataRead = data;
        push(1'b0, data);
        tick();
        chk("rd_en", 32'(peripheralEnable), 32'd1);
        chk("rd_oe", 32'(peripheralBus_oe), 32'd1);
        chk("rd_we", 32'(peripheralBus_we), 32'd0);
        chk("rd_addr", 32'(peripheralBus_address), 32'(adr));
        wb_stb_i = 1'b0;
        tick();
        chk("rd_en_off", 32'(peripheralEnable), 32'd0);
        chk("rd_ack_t2", 32'(wb_ack_o), 32'd1);
        tick();
        chk("rd_data_clr", wb_data_o, 32'd0);
        chk("rd_stall_idle", 32'(wb_stall_o), 32'd0);
        wb_cyc_i = 1'b0;
    endtask

    // Monitor: every ack/error must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_ack_o || wb_error_o) begin
            chk("resp_exclusive", 32'(wb_ack_o & wb_error_o), 32'd0);
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_err", 32'(wb_error_o), 32'(e.err));
                chk("resp_data", wb_data_o, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 4'd0; wb_adr_i = 16'd0; wb_data_i = 32'd0;
        peripheralBus_dataRead = 32'd0; peripheralBus_busy = 1'b0;
        tick();
        tick();
        chk("rst_stall", 32'(wb_stall_o), 32'd0);
        chk("rst_en", 32'(peripheralEnable), 32'd0);
        chk("rst_addr", 32'(peripheralBus_address), 32'd0);
        chk("rst_data", wb_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // Read, zero wait.
        read0(16'h3004, 32'hDEADBEEF);
        tick();

        // Write with three busy cycles.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'b0011;
        wb_adr_i = 16'h1010; wb_data_i = 32'h12345678; peripheralBus_busy = 1'b1;
        push(1'b0, 32'd0);
        tick();
        wb_stb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_we", 32'(peripheralBus_we), 32'd1);
            chk("wr_oe", 32'(peripheralBus_oe), 32'd0);
            chk("wr_sel", 32'(peripheralBus_byteSelect), 32'h3);
            chk("wr_dw", peripheralBus_dataWrite, 32'h12345678);
            chk("wr_ack_early", 32'(wb_ack_o), 32'd0);
            if (i == 3) peripheralBus_busy = 1'b0;
            tick();
        end
        chk("wr_we_off", 32'(peripheralBus_we), 32'd0);
        chk("wr_ack_t5", 32'(wb_ack_o), 32'd1);
        chk("wr_err", 32'(wb_error_o), 32'd0);
        tick();
        wb_cyc_i = 1'b0;
        tick();

        // Timeout with busy stuck.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_adr_i = 16'h2000; peripheralBus_busy = 1'b1; peripheralBus_dataRead = 32'h55AA55AA;
        push(1'b1, 32'd0);
        tick();
        wb_stb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_en", 32'(peripheralEnable), 32'd1);
            chk("to_ack", 32'(wb_ack_o), 32'd0);
            tick();
        end
        chk("to_en_off", 32'(peripheralEnable), 32'd0);
        chk("to_err_t5", 32'(wb_error_o), 32'd1);
        chk("to_ack_t5", 32'(wb_ack_o), 32'd0);
        chk("to_data", wb_data_o, 32'd0);
        peripheralBus_busy = 1'b0;
        tick();
        chk("to_err_once", 32'(wb_error_o), 32'd0);
        wb_cyc_i = 1'b0;
        tick();

        // Abort on the second ACCESS cycle.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h2222;
        peripheralBus_busy = 1'b1;
        tick();
        wb_stb_i = 1'b0;
        tick();
        chk("ab_en_2nd", 32'(peripheralEnable), 32'd1);
        wb_cyc_i = 1'b0;
        tick();
        chk("ab_en_off", 32'(peripheralEnable), 32'd0);
        chk("ab_stall", 32'(wb_stall_o), 32'd0);
        tick();
        chk("ab_no_resp", 32'(wb_ack_o | wb_error_o), 32'd0);
        read0(16'h4008, 32'hA5A50F0F);
        tick();

        // Back-to-back reads with stb held through the stall.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_adr_i = 16'h0100; peripheralBus_busy = 1'b0; peripheralBus_dataRead = 32'h11111111;
        push(1'b0, 32'h11111111);
        push(1'b0, 32'h22222222);
        chk("bb_stall0", 32'(wb_stall_o), 32'd0);
        tick();
        chk("bb_stall1", 32'(wb_stall_o), 32'd1);
        chk("bb_addr_a", 32'(peripheralBus_address), 32'h0100);
        wb_adr_i = 16'h0200;
        tick();
        chk("bb_stall2", 32'(wb_stall_o), 32'd1);
        chk("bb_ack_a", 32'(wb_ack_o), 32'd1);
        chk("bb_addr_hold", 32'(peripheralBus_address), 32'h0100);
        peripheralBus_dataRead = 32'h22222222;
        tick();
        chk("bb_stall3", 32'(wb_stall_o), 32'd0);
        chk("bb_addr_hold2", 32'(peripheralBus_address), 32'h0100);
        tick();
        wb_stb_i = 1'b0;
        chk("bb_stall4", 32'(wb_stall_o), 32'd1);
        chk("bb_addr_b", 32'(peripheralBus_address), 32'h0200);
        tick();
        chk("bb_stall5", 32'(wb_stall_o), 32'd1);
        chk("bb_ack_b", 32'(wb_ack_o), 32'd1);
        tick();
        wb_cyc_i = 1'b0;
        tick();

        // Reset during a busy write.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'b1100;
        wb_adr_i = 16'h5550; wb_data_i = 32'hCAFEF00D; peripheralBus_busy = 1'b1;
        tick();
        wb_stb_i = 1'b0;
        chk("rs_we_before", 32'(peripheralBus_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; wb_cyc_i = 1'b0; peripheralBus_busy = 1'b0;
        chk("rs_en", 32'(peripheralEnable), 32'd0);
        chk("rs_we", 32'(peripheralBus_we), 32'd0);
        chk("rs_stall", 32'(wb_stall_o), 32'd0);
        chk("rs_addr", 32'(peripheralBus_address), 32'd0);
        chk("rs_sel", 32'(peripheralBus_byteSelect), 32'd0);
        chk("rs_dw", peripheralBus_dataWrite, 32'd0);
        tick();
        chk("rs_no_resp", 32'(wb_ack_o | wb_error_o), 32'd0);
        read0(16'h6006, 32'h0BADF00D);

        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_bridge.md
# peripheral_bus_bridge

Wishbone slave that converts single 32-bit bus cycles from the management core into peripheral-bus transactions. It drives `peripheralEnable` and `peripheralBus_address`, which every peripheral's device-select decode consumes. It also returns the read data to the Wishbone side, or an error response when the addressed peripheral holds `peripheralBus_busy` too long. The bridge sits between the Wishbone interconnect and the peripheral register blocks, with one outstanding transaction at a time.

## Interface
- `TIMEOUT_CYCLES`, default 8'd255: number of consecutive busy cycles in ACCESS before an error response; legal range 1..255.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `wb_cyc_i`  input  1  Wishbone cycle.
- `wb_stb_i`  input  1  Wishbone strobe.
- `wb_we_i`  input  1  Wishbone write enable.
- `wb_sel_i`  input  4  byte selects.
- `wb_adr_i`  input  16  byte address; passed through unchanged.
- `wb_data_i`  input  32  write data.
- `wb_ack_o`  output  1  one-cycle success acknowledge.
- `wb_error_o`  output  1  one-cycle timeout error; mutually exclusive with ack.
- `wb_stall_o`  output  1  high whenever state is not IDLE.
- `wb_data_o`  output  32  read data; valid with ack; 0 otherwise.
- `peripheralEnable`  output  1  high for the whole ACCESS state.
- `peripheralBus_address`  output  16  latched `wb_adr_i`.
- `peripheralBus_we`  output  1  `peripheralEnable` AND latched we.
- `peripheralBus_oe`  output  1  `peripheralEnable` AND NOT latched we.
- `peripheralBus_byteSelect`  output  4  latched `wb_sel_i`.
- `peripheralBus_dataWrite`  output  32  latched `wb_data_i`.
- `peripheralBus_dataRead`  input  32  read data from the selected device.
- `peripheralBus_busy`  input  1  device not ready; ORed across all devices upstream.

## Operation
- States:
  - IDLE: no transaction.
  - ACCESS: peripheral access in progress.
  - RESPOND: one cycle presenting the response.
- IDLE:
  - `wb_stall_o`=0.
  - When `wb_cyc_i && wb_stb_i` is sampled, latch address, we, sel and write data, clear the timeout counter, and go to ACCESS.
- ACCESS:
  - `peripheralEnable`=1 and `wb_stall_o`=1. Each edge samples `peripheralBus_busy`.
  - busy=0: if a read, register `peripheralBus_dataRead` into `wb_data_o`. Set the ack flag and go to RESPOND.
  - busy=1 and counter == `TIMEOUT_CYCLES`-1: set the error flag and go to RESPOND. `wb_data_o` stays 0.
  - busy=1 otherwise: increment the counter (8-bit, never wraps) and stay in ACCESS.
  - `wb_cyc_i`=0 sampled: abort. Go to IDLE, no ack or error; this takes priority over busy/timeout.
- RESPOND:
  - Exactly one of `wb_ack_o` or `wb_error_o` is 1 for this single cycle, and `wb_stall_o`=1.
  - The next state is IDLE. `wb_data_o` clears to 0 when leaving RESPOND.
  - A strobe presented during RESPOND is stalled and accepted from IDLE.
- Latched peripheral outputs hold their values outside ACCESS; only `peripheralEnable`, `peripheralBus_we` and `peripheralBus_oe` gate activity.
- Reset:
  - State goes to IDLE. Every output and internal register resets to 0, including address, byteSelect, dataWrite, `wb_data_o` and the counter.
  - Reset mid-ACCESS drops `peripheralEnable` on the next edge, with no response issued.

## Timing
- Strobe sampled at edge T (IDLE) → `peripheralEnable` high during cycle T+1.
- busy=0 at edge T+1 → ack high in cycle T+2 → IDLE at T+3. The minimum request-to-ack latency is 2 cycles.
- A new strobe is accepted at the earliest at edge T+3, so back-to-back transactions occupy 3 cycles each.
- busy held for k consecutive ACCESS edges (k < `TIMEOUT_CYCLES`), then low → ack in cycle T+2+k.
- busy held continuously → error high in cycle T+1+`TIMEOUT_CYCLES`. `peripheralEnable` is high for exactly `TIMEOUT_CYCLES` cycles.
- The write strobe is level: a device acts on the first cycle in which `peripheralBus_we`=1 and its own busy is 0.

## Test plan
- Read, zero wait: addr 16'h3004, dataRead 32'hDEADBEEF, busy=0 → enable 1 cycle, oe=1, ack at T+2, `wb_data_o`=32'hDEADBEEF for 1 cycle, then 0.
- Write with waits: addr 16'h1010, data 32'h12345678, sel 4'b0011, busy high 3 cycles → we=1 for 4 cycles, byteSelect=4'b0011, ack at T+5, no error.
- Timeout: `TIMEOUT_CYCLES`=4, busy stuck high → enable high 4 cycles, `wb_error_o`=1 at T+5, ack never asserted, `wb_data_o`=0.
- Abort: `wb_cyc_i` dropped on the second ACCESS cycle with busy=1 → enable low on the next cycle, no ack or error, and the next strobe is accepted normally.
- Back-to-back: two reads held on stb with stall honoured → stall pattern 0,1,1,0,1,1; acks at T+2 and T+5; addresses update only on acceptance.
- Reset mid-ACCESS: `rst` asserted for 1 cycle during busy → all outputs 0 on the next cycle, state IDLE, no response; the following transaction completes normally.
